// File: rtl/e203_ifu_flush_redirect.sv
// e203_ifu_flush_redirect: IFU flush acceptance, stale-response drop and fetch-PC redirect.
// Optional zero-cycle redirect when E203_FLUSH_FAST_REDIR_EN is defined.
module e203_ifu_flush_redirect #(
    parameter int PC_W     = 32,
    parameter int MAX_OUTS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush_req,
    input  logic [PC_W-1:0] pipe_flush_add_op1,
    input  logic [PC_W-1:0] pipe_flush_add_op2,
    output logic            pipe_flush_ack,
    input  logic            ifu_req_hsked,
    input  logic            ifu_rsp_hsked,
    output logic            ifu_req_allow,
    output logic            ifu_rsp_drop,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush_busy
);
    localparam int CW = $clog2(MAX_OUTS + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, REDIR} state_t;

    state_t          state;
    logic [CW-1:0]   outs_cnt, drop_cnt, eff_cnt;
    logic [PC_W-1:0] pc_r, flush_pc;
    logic            idle, fast;

    assign idle     = (state == IDLE);
    assign flush_pc = pipe_flush_add_op1 + pipe_flush_add_op2;
    // A response landing in the ack cycle is already consumed, so it needs no drop.
    assign eff_cnt  = outs_cnt - CW'(ifu_rsp_hsked);

`ifdef E203_FLUSH_FAST_REDIR_EN
    assign fast = idle & pipe_flush_req & (eff_cnt == '0);
`else
    assign fast = 1'b0;
`endif

    assign pipe_flush_ack = pipe_flush_req & idle & (~fast | redirect_ready);
    assign ifu_req_allow  = idle & ~pipe_flush_req & (outs_cnt < CW'(MAX_OUTS));
    assign ifu_rsp_drop   = ifu_rsp_hsked & (state == DRAIN);
    assign redirect_valid = (state == REDIR) | fast;
    assign redirect_pc    = fast ? flush_pc : pc_r;
    assign flush_busy     = ~idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            outs_cnt <= '0;
            drop_cnt <= '0;
            pc_r     <= '0;
        end else begin
            outs_cnt <= outs_cnt + CW'(ifu_req_hsked) - CW'(ifu_rsp_hsked);
            case (state)
                IDLE: if (pipe_flush_ack && !fast) begin
                    pc_r     <= flush_pc;
                    drop_cnt <= eff_cnt;
                    state    <= (eff_cnt != '0) ? DRAIN : REDIR;
                end
                DRAIN: if (ifu_rsp_hsked) begin
                    drop_cnt <= drop_cnt - CW'(1);
                    state    <= (drop_cnt == CW'(1)) ? REDIR : DRAIN;
                end
                REDIR: state <= redirect_ready ? IDLE : REDIR;
                default: state <= IDLE;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(ifu_rsp_hsked && outs_cnt == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(ifu_req_hsked && !ifu_rsp_hsked && outs_cnt == CW'(MAX_OUTS)));
endmodule

// File: doc/e203_ifu_flush_redirect.md
E203_IFU_FLUSH_REDIRECT -- requirements
Module: e203_ifu_flush_redirect

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning flush-PC and adder-operand width (E203_PC_SIZE).
REQ-002 SHALL have parameter MAX_OUTS, default 2, meaning maximum outstanding IFU fetch requests (1..3).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port pipe_flush_req  in  1  flush request from commit stage; held until acked.
REQ-006 SHALL have port pipe_flush_add_op1  in  PC_W  flush-PC adder operand 1.
REQ-007 SHALL have port pipe_flush_add_op2  in  PC_W  flush-PC adder operand 2.
REQ-008 SHALL have port pipe_flush_ack  out  1  flush accepted this cycle.
REQ-009 SHALL have port ifu_req_hsked  in  1  fetch request handshake to memory.
REQ-010 SHALL have port ifu_rsp_hsked  in  1  fetch response handshake from memory.
REQ-011 SHALL have port ifu_req_allow  out  1  new fetch request permitted.
REQ-012 SHALL have port ifu_rsp_drop  out  1  current response is stale; discard.
REQ-013 SHALL have port redirect_valid  out  1  new fetch PC available.
REQ-014 SHALL have port redirect_pc  out  PC_W  new fetch PC.
REQ-015 SHALL have port redirect_ready  in  1  fetch unit accepts redirect.
REQ-016 SHALL have port flush_busy  out  1  state is not IDLE.

Function
REQ-017 outs_cnt SHALL increment on ifu_req_hsked only, decrement on ifu_rsp_hsked only, and be unchanged on both or neither.
REQ-018 ifu_req_allow SHALL be (state==IDLE) & ~pipe_flush_req & (outs_cnt<MAX_OUTS).
REQ-019 FSM states SHALL be IDLE, DRAIN, REDIR.
REQ-020 pipe_flush_ack SHALL be pipe_flush_req & (state==IDLE), except as modified by REQ-030.
REQ-021 On ack, pc_r SHALL load (op1+op2) mod 2^PC_W; carry-out discarded.
REQ-022 On ack, drop_cnt SHALL load outs_cnt minus ifu_rsp_hsked of the same cycle; next state DRAIN if that value is nonzero, else REDIR.
REQ-023 ifu_rsp_drop SHALL be ifu_rsp_hsked & (state==DRAIN).
REQ-024 In DRAIN, each ifu_rsp_hsked SHALL decrement drop_cnt; when drop_cnt reaches 0, next state SHALL be REDIR.
REQ-025 In REDIR, redirect_valid SHALL be 1 and redirect_pc SHALL be pc_r, stable until redirect_ready; on redirect_ready, next state SHALL be IDLE.
REQ-026 redirect_valid SHALL be 0 in IDLE and DRAIN, except as modified by REQ-030.
REQ-027 pipe_flush_req asserted in DRAIN or REDIR SHALL NOT be acked until IDLE is reached.
REQ-028 outs_cnt SHALL never exceed MAX_OUTS or underflow; ifu_rsp_hsked with outs_cnt==0 is illegal and is flagged by a simulation assertion.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, outs_cnt=0, drop_cnt=0, pc_r=0; all outputs 0 except ifu_req_allow=1 when pipe_flush_req=0.

Configuration
REQ-030 Macro E203_FLUSH_FAST_REDIR_EN. When defined, in IDLE with pipe_flush_req and effective outstanding count (REQ-022) equal to 0: redirect_valid=1 combinationally, redirect_pc=op1+op2, pipe_flush_ack=redirect_ready, state stays IDLE (zero-cycle redirect). When undefined, every flush passes through REDIR (minimum 1-cycle latency from ack to redirect_valid).

Verification
REQ-031 Idle flush: outs_cnt=0, op1=0x8000_0000, op2=0x10 -> ack same cycle, redirect_valid next cycle, redirect_pc=0x8000_0010 (with macro: redirect_valid same cycle).
REQ-032 Drain: two requests outstanding, flush acked -> next two responses have ifu_rsp_drop=1, then REDIR, ifu_req_allow=0 throughout.
REQ-033 Simultaneous events: response handshake in ack cycle with outs_cnt=1 -> drop_cnt=0, direct to REDIR, no drop asserted.
REQ-034 Wrap: op1=0xFFFF_FFF0, op2=0x20 -> redirect_pc=0x0000_0010.
REQ-035 Backpressure: redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc held; second pipe_flush_req not acked until a cycle after IDLE is reached.
REQ-036 Reset in DRAIN with drop_cnt=1 -> state IDLE, flush_busy=0, outs_cnt=0 immediately.
